// File: rtl/result_stream_buffer.sv
// Holds an NxN matrix of 32-bit products written at random and replays it
// row-major over a valid/ready stream, tagging each beat with its row/column.
module result_stream_buffer #(
  parameter int unsigned N    = 8,
  parameter int unsigned NLen = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [NLen:0]   wr_row_i,
  input  logic [NLen:0]   wr_col_i,
  input  logic [31:0]     wr_data_i,
  input  logic            load_done_i,
  input  logic            start_i,
  input  logic            clear_i,
  output logic [31:0]     out_value_o,
  output logic [NLen:0]   out_row_o,
  output logic [NLen:0]   out_col_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned IdxW  = NLen + 1;
  localparam int unsigned Depth = N * N;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StReady, StStream, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [Depth];
  logic [IdxW-1:0] row_q, row_d, col_q, col_d;
  logic [31:0]     value_q, value_d;
  logic            valid_q, valid_d;
  logic            wr_ok;

  function automatic logic [AddrW-1:0] addr_of(input logic [IdxW-1:0] r,
                                               input logic [IdxW-1:0] c);
    int unsigned a;
    a = 32'(r) * N + 32'(c);
    return AddrW'(a);
  endfunction

  // Writes only land while loading; out-of-range indices are dropped, not aliased.
  assign wr_ok = wr_en_i && (state_q == StIdle || state_q == StReady) &&
                 (32'(wr_row_i) < N) && (32'(wr_col_i) < N);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[addr_of(wr_row_i, wr_col_i)] <= wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    value_d = value_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (load_done_i) state_d = StReady;
      end
      StReady: begin
        if (start_i) begin
          state_d = StStream;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b1;
          value_d = mem_q[addr_of('0, '0)];
        end
      end
      StStream: begin
        if (valid_q && out_ready_i) begin
          if (row_q == LastIdx && col_q == LastIdx) begin
            valid_d = 1'b0;
            state_d = StDone;
          end else begin
            if (col_q == LastIdx) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            value_d = mem_q[addr_of(row_d, col_d)];
          end
        end
      end
      StDone: begin
        if (clear_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign out_value_o = value_q;
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;
  assign out_valid_o = valid_q;
  assign busy_o      = (state_q == StStream);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_result_stream_buffer.sv
// Randomized bench for result_stream_buffer: a plain array model of the matrix
// predicts every streamed beat in row-major order.
module tb_result_stream_buffer;

  localparam int unsigned N     = 8;
  localparam int unsigned NLen  = $clog2(N);
  localparam int unsigned IW    = NLen + 1;
  localparam int unsigned Depth = N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_row = '0;
  logic [IW-1:0] wr_col = '0;
  logic [31:0]   wr_data = '0;
  logic          load_done = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   out_value;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] model_mem  [Depth];
  logic [31:0] stream_mem [Depth];

  result_stream_buffer #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_row_i    (wr_row),
    .wr_col_i    (wr_col),
    .wr_data_i   (wr_data),
    .load_done_i (load_done),
    .start_i     (start),
    .clear_i     (clear),
    .out_value_o (out_value),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int r, input int c, input logic [31:0] d);
    wr_en = 1'b1; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_load();
    load_done = 1'b1; step(); load_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic fill_random();
    logic [31:0] d;
    for (int i = 0; i < int'(Depth); i++) begin
      d = $urandom;
      write_cell(i / N, i % N, d);
      model_mem[i] = d;
    end
  endtask

  // mode 0: ready high; 1: alternate plus 5-cycle stall at [3][2]; 2: random ready
  task automatic drain(input int mode, input string tag);
    int beats = 0;
    int busy_cnt = 0;
    int burst = 5;
    bit stall = 1'b0;
    bit rdy;
    logic [31:0] pv;
    logic [IW-1:0] pr, pc;
    for (int cyc = 0; cyc < 2000 && beats < int'(Depth); cyc++) begin
      if (stall) begin
        vectors++;
        if ({out_valid, out_value, out_row, out_col} !== {1'b1, pv, pr, pc}) begin
          errors++;
          $display("FAIL %s hold: got v=%b val=%h r=%0d c=%0d, want v=1 val=%h r=%0d c=%0d",
                   tag, out_valid, out_value, out_row, out_col, pv, pr, pc);
        end
      end
      if (busy) busy_cnt++;
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) begin
        if (out_valid && out_row == IW'(3) && out_col == IW'(2) && burst > 0) begin
          rdy = 1'b0;
          burst--;
        end else rdy = cyc[0];
      end else rdy = ($urandom_range(0, 3) != 0);
      if (out_valid && rdy) begin
        vectors++;
        if ({out_value, out_row, out_col} !==
            {stream_mem[beats], IW'(beats / N), IW'(beats % N)}) begin
          errors++;
          $display("FAIL %s beat %0d: got val=%h r=%0d c=%0d, want val=%h r=%0d c=%0d",
                   tag, beats, out_value, out_row, out_col, stream_mem[beats],
                   beats / N, beats % N);
        end
        beats++;
      end
      stall = out_valid && !rdy;
      pv = out_value; pr = out_row; pc = out_col;
      out_ready = rdy;
      step();
    end
    out_ready = 1'b0;
    vectors++;
    if (beats != int'(Depth)) begin
      errors++;
      $display("FAIL %s beat count: got %0d, want %0d", tag, beats, Depth);
    end
    vectors++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s end state: got done=%b busy=%b valid=%b, want done=1 busy=0 valid=0",
               tag, done, busy, out_valid);
    end
    if (mode == 0) begin
      vectors++;
      if (busy_cnt != int'(Depth)) begin
        errors++;
        $display("FAIL %s busy cycles: got %0d, want %0d", tag, busy_cnt, Depth);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({out_valid, busy, done, out_value, out_row, out_col} !== '0) begin
      errors++;
      $display("FAIL reset in-reset: got v=%b b=%b d=%b val=%h r=%0d c=%0d, want all 0",
               out_valid, busy, done, out_value, out_row, out_col);
    end
    #9 rst_n = 1'b1;
    step();
    pulse_start();
    step();
    vectors++;
    if ({out_valid, busy, done, out_value, out_row, out_col} !== '0) begin
      errors++;
      $display("FAIL reset idle-start: got v=%b b=%b d=%b val=%h, want all 0",
               out_valid, busy, done, out_value);
    end
  endtask

  task automatic test_fill_stream();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        write_cell(r, c, 32'(r * 16 + c));
        model_mem[r * N + c] = 32'(r * 16 + c);
      end
    pulse_load();
    stream_mem = model_mem;
    pulse_start();
    drain(0, "fill");
  endtask

  task automatic test_backpressure();
    pulse_clear();
    fill_random();
    write_cell(3, 2, 32'h32);
    model_mem[3 * N + 2] = 32'h32;
    pulse_load();
    stream_mem = model_mem;
    pulse_start();
    drain(1, "backpressure");
  endtask

  task automatic test_ignored();
    pulse_start();
    step();
    vectors++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL start-in-done: got done=%b busy=%b valid=%b, want 1 0 0",
               done, busy, out_valid);
    end
    pulse_clear();
    pulse_start();
    step();
    vectors++;
    if ({done, busy, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL start-in-idle: got done=%b busy=%b valid=%b, want 0 0 0",
               done, busy, out_valid);
    end
    pulse_load();
    stream_mem = model_mem;
    pulse_start();
    // write, load_done and start during a stalled STREAM cycle must all be ignored
    wr_en = 1'b1; wr_row = '0; wr_col = IW'(5); wr_data = 32'hDEAD;
    load_done = 1'b1; start = 1'b1; out_ready = 1'b0;
    step();
    wr_en = 1'b0; load_done = 1'b0; start = 1'b0;
    drain(2, "ignored");
    pulse_clear();
    pulse_load();
    pulse_start();
    drain(0, "replay");
  endtask

  task automatic test_boundaries();
    logic [31:0] d;
    logic [31:0] nv;
    pulse_clear();
    write_cell(8, 0, 32'hBAD0_0001);
    write_cell(0, 8, 32'hBAD0_0002);
    write_cell(9, 3, 32'hBAD0_0003);
    write_cell(15, 15, 32'hBAD0_0004);
    d = $urandom;
    load_done = 1'b1;
    write_cell(2, 2, d);
    load_done = 1'b0;
    model_mem[2 * N + 2] = d;
    write_cell(4, 4, $urandom);
    d = $urandom;
    write_cell(4, 4, d);
    model_mem[4 * N + 4] = d;
    nv = model_mem[0] ^ 32'h0000_0001;
    stream_mem = model_mem;
    start = 1'b1;
    write_cell(0, 0, nv);
    start = 1'b0;
    model_mem[0] = nv;
    drain(2, "boundary");
    pulse_clear();
    pulse_load();
    stream_mem = model_mem;
    pulse_start();
    drain(0, "boundary-replay");
  endtask

  task automatic test_reset_midstream();
    int guard = 0;
    pulse_clear();
    pulse_load();
    pulse_start();
    out_ready = 1'b1;
    while (!(out_valid && out_row == IW'(2) && out_col == IW'(4)) && guard < 200) begin
      step();
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL midstream reach [2][4]: got timeout, want element within 200 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, done, out_value, out_row, out_col} !== '0) begin
      errors++;
      $display("FAIL midstream reset: got v=%b b=%b d=%b val=%h r=%0d c=%0d, want all 0",
               out_valid, busy, done, out_value, out_row, out_col);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pulse_start();
    step();
    vectors++;
    if ({done, busy, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL post-reset start: got done=%b busy=%b valid=%b, want 0 0 0",
               done, busy, out_valid);
    end
    pulse_load();
    stream_mem = model_mem;
    pulse_start();
    drain(2, "post-reset");
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_backpressure();
    test_ignored();
    test_boundaries();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
